// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch PC register and IF/ID pipeline latch
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        PCWrite_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branchTarget_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] IFID_pc_o,
    output logic [31:0] IFID_instr_o,
    output logic        IFID_valid_o,
    output logic [15:0] stallCount_o
);

    // PC register: redirect beats hazard hold, which beats fetch-disable hold.
    // The increment wraps naturally at 2^32 and the branch target is taken as-is.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_o <= RESET_PC;
        end else if (flush_i) begin
            pc_o <= branchTarget_i;
        end else if (PCWrite_i && start_i) begin
            pc_o <= pc_o + 32'd4;
        end
    end

    // IF/ID latch: flush squashes, stall holds, disabled fetch inserts a bubble.
    // A stall with PCWrite still high lets the PC run ahead; that instruction is lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            IFID_pc_o    <= 32'h0000_0000;
            IFID_instr_o <= 32'h0000_0000;
            IFID_valid_o <= 1'b0;
        end else if (flush_i) begin
            IFID_pc_o    <= 32'h0000_0000;
            IFID_instr_o <= 32'h0000_0000;
            IFID_valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (start_i) begin
                IFID_pc_o    <= pc_o;
                IFID_instr_o <= instr_i;
                IFID_valid_o <= 1'b1;
            end else begin
                IFID_pc_o    <= 32'h0000_0000;
                IFID_instr_o <= 32'h0000_0000;
                IFID_valid_o <= 1'b0;
            end
        end
    end

    // Stall cycle counter: only genuine stalls count (a flush overrides the stall), saturating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stallCount_o <= 16'h0000;
        end else if (stall_i && !flush_i && (stallCount_o != 16'hFFFF)) begin
            stallCount_o <= stallCount_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard bench for if_id_stage against a reference model
`timescale 1ns/1ps
module tb_if_id_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        PCWrite_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] branchTarget_i;
    logic [31:0] instr_i;
    logic [31:0] pc_o;
    logic [31:0] IFID_pc_o;
    logic [31:0] IFID_instr_o;
    logic        IFID_valid_o;
    logic [15:0] stallCount_o;

    if_id_stage #(.RESET_PC(RESET_PC)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .PCWrite_i      (PCWrite_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .branchTarget_i (branchTarget_i),
        .instr_i        (instr_i),
        .pc_o           (pc_o),
        .IFID_pc_o      (IFID_pc_o),
        .IFID_instr_o   (IFID_instr_o),
        .IFID_valid_o   (IFID_valid_o),
        .stallCount_o   (stallCount_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory: content derived from the address
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    assign instr_i = mem_f(pc_o);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifinstr;
        logic        v;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    longint      m_pc;
    longint      m_ifpc;
    logic [31:0] m_ifinstr;
    logic        m_v;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_ifpc = 0; m_ifinstr = 0; m_v = 0; m_cnt = 0;
    endtask

    // One clock cycle: drive inputs at the falling edge, predict the post-edge state
    task automatic step(input logic st, input logic pw, input logic sl, input logic fl,
                        input logic [31:0] tgt);
        longint      n_pc;
        longint      n_ifpc;
        logic [31:0] n_ifinstr;
        logic        n_v;
        exp_t        e;
        start_i = st; PCWrite_i = pw; stall_i = sl; flush_i = fl; branchTarget_i = tgt;
        if (fl)            n_pc = tgt;
        else if (pw && st) n_pc = (m_pc + 4) % 64'h1_0000_0000;
        else               n_pc = m_pc;
        if (fl) begin
            n_ifpc = 0; n_ifinstr = 0; n_v = 0;
        end else if (sl) begin
            n_ifpc = m_ifpc; n_ifinstr = m_ifinstr; n_v = m_v;
        end else if (!st) begin
            n_ifpc = 0; n_ifinstr = 0; n_v = 0;
        end else begin
            n_ifpc = m_pc; n_ifinstr = mem_f(32'(m_pc)); n_v = 1;
        end
        if (sl && !fl && m_cnt < 65535) m_cnt = m_cnt + 1;
        m_pc = n_pc; m_ifpc = n_ifpc; m_ifinstr = n_ifinstr; m_v = n_v;
        e.pc = 32'(m_pc); e.ifpc = 32'(m_ifpc); e.ifinstr = m_ifinstr; e.v = m_v;
        e.cnt = 16'(m_cnt);
        exp_q.push_back(e);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Monitor: after every edge, compare the DUT against the oldest prediction
    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pc", pc_o, e.pc);
            check("ifid_pc", IFID_pc_o, e.ifpc);
            check("ifid_instr", IFID_instr_o, e.ifinstr);
            check("ifid_valid", {31'd0, IFID_valid_o}, {31'd0, e.v});
            check("stall_count", {16'd0, stallCount_o}, {16'd0, e.cnt});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 0; PCWrite_i = 0; stall_i = 0; flush_i = 0;
        branchTarget_i = 0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check("reset_pc", pc_o, RESET_PC);
        check("reset_valid", {31'd0, IFID_valid_o}, 32'd0);
        check("reset_count", {16'd0, stallCount_o}, 32'd0);
        rst_i = 1'b0;

        // Fetch disabled after reset: PC must not move
        step(0, 1, 0, 0, 0);
        check("start_hold_pc", pc_o, 32'h0);

        // Sequential fetch then a load-use stall at pc 8
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("seq_pc8", pc_o, 32'h8);
        step(1, 0, 1, 0, 0);
        check("loaduse_pc", pc_o, 32'h8);
        check("loaduse_ifpc", IFID_pc_o, 32'h4);
        check("loaduse_cnt", {16'd0, stallCount_o}, 32'd1);
        step(1, 1, 0, 0, 0);
        check("resume_pc", pc_o, 32'hC);
        check("resume_ifpc", IFID_pc_o, 32'h8);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("seq_pc20", pc_o, 32'h14);

        // Flush beats stall and PCWrite hold
        step(1, 0, 1, 1, 32'h40);
        check("flush_pc", pc_o, 32'h40);
        check("flush_valid", {31'd0, IFID_valid_o}, 32'd0);
        check("flush_cnt", {16'd0, stallCount_o}, 32'd1);
        step(1, 1, 0, 0, 0);
        check("redirect_ifpc", IFID_pc_o, 32'h40);

        // PC wrap at top of address space
        step(1, 1, 0, 1, 32'hFFFF_FFFC);
        step(1, 1, 0, 0, 0);
        check("wrap_pc", pc_o, 32'h0);
        check("wrap_ifpc", IFID_pc_o, 32'hFFFF_FFFC);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), $urandom);
        end

        // Asynchronous reset between edges, mid-stall with a flush pending
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        #2;
        flush_i = 1; branchTarget_i = 32'h1234_5678; stall_i = 1;
        rst_i = 1'b1;
        #1;
        check("async_rst_pc", pc_o, RESET_PC);
        check("async_rst_valid", {31'd0, IFID_valid_o}, 32'd0);
        check("async_rst_cnt", {16'd0, stallCount_o}, 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        step(1, 1, 0, 0, 0);
        check("post_rst_ifpc", IFID_pc_o, RESET_PC);
        check("post_rst_valid", {31'd0, IFID_valid_o}, 32'd1);

        // Stall counter saturation
        for (int i = 0; i < 65540; i++) step(1, 0, 1, 0, 0);
        check("sat_cnt", {16'd0, stallCount_o}, 32'h0000_FFFF);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
